// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared types and widths for the memory-bus initiator.
package mem_master_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_ADDR_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT_WR,
      READ,
      RESP
   } mem_master_state_e;

endpackage

// File: rtl/mem_master_timeout.sv
// mem_master_timeout: wait-cycle counter for the memory completion timeout.
// Only instantiated when MEM_MASTER_TIMEOUT_EN is defined.
module mem_master_timeout #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Expiry is flagged during the last allowed wait cycle so the FSM leaves on
   // the edge where the count reaches TIMEOUT_CYCLES.
   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

   // Count cycles spent waiting; restart on entry to a wait state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CW'(1);
   end

endmodule

// File: rtl/mem_master.sv
// mem_master: single-outstanding load/store initiator for the word memory bus.
// Optional completion timeout enabled by defining MEM_MASTER_TIMEOUT_EN.
module mem_master
   import mem_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [MEM_ADDR_W-1:0] req_addr,
   input  logic [MEM_DATA_W-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [MEM_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_wr,
   output logic                  mem_rd,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [MEM_DATA_W-1:0] mem_wdata,
   input  logic [MEM_DATA_W-1:0] mem_rdata,
   input  logic                  mem_write_done,
   input  logic                  mem_available
);

   mem_master_state_e state, state_next;

   logic                  ready_q;
   logic [MEM_ADDR_W-1:0] addr_q;
   logic [MEM_DATA_W-1:0] wdata_q;
   logic [MEM_DATA_W-1:0] rdata_q;
   logic                  accept;
   logic                  wr_done;
   logic                  rd_done;
   logic                  expired;

   // ready_q mirrors "state is IDLE" but is held low through reset, so the
   // core sees ready only from the first edge after release.
   assign accept  = req_valid && ready_q;
   assign wr_done = (state == WAIT_WR) && mem_write_done;
   assign rd_done = (state == READ) && mem_available;

   assign req_ready = ready_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_rdata = rdata_q;

`ifdef MEM_MASTER_TIMEOUT_EN
   logic tmo_clear;
   logic tmo_en;
   logic err_q;

   // Counter restarts on the edge that enters WAIT_WR (from WRITE) or READ.
   assign tmo_clear = (state == WRITE) || ((state == IDLE) && accept && !req_we);
   assign tmo_en    = (state == WAIT_WR) || (state == READ);

   mem_master_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmo_clear),
      .enable (tmo_en),
      .expired(expired)
   );

   // Error flag: real completion on the expiry edge takes precedence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (wr_done || rd_done)
         err_q <= 1'b0;
      else if (expired)
         err_q <= 1'b1;
   end

   assign rsp_err = err_q;
`else
   assign expired = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic and strobes decoded from the current state.
   always_comb begin
      state_next = state;
      mem_wr     = 1'b0;
      mem_rd     = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state)
         IDLE:    if (accept) state_next = req_we ? WRITE : READ;
         WRITE: begin
            mem_wr     = 1'b1;
            state_next = WAIT_WR;
         end
         WAIT_WR: if (mem_write_done || expired) state_next = RESP;
         READ: begin
            mem_rd = 1'b1;
            if (mem_available || expired) state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, ready flag and response data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         ready_q <= (state_next == IDLE);
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (rd_done)
            rdata_q <= mem_rdata;
         else if (wr_done || expired)
            rdata_q <= '0;
      end
   end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: table-driven load/store vectors with a response scoreboard,
// plus hand sequences for stall, reset-in-flight and (if enabled) timeout.
`timescale 1ns/1ps
module tb_mem_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_write_done = 1'b0;
   logic        mem_available;
   logic        force_unavail = 1'b0;

   always #5 clk = ~clk;

   mem_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .mem_wr        (mem_wr),
      .mem_rd        (mem_rd),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_write_done(mem_write_done),
      .mem_available (mem_available)
   );

   // Standard memory: registered write_done, combinational available.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
      mem_write_done <= mem_wr;
   end
   assign mem_available = mem_rd && !force_unavail;
   assign mem_rdata     = mem[mem_addr[7:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;   // edges from accept edge to first rsp_valid
      int          nwr;   // mem_wr cycles expected
      int          nrd;   // mem_rd cycles expected
      int          acc;   // cycle index of the accept edge
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          gap;   // cycles since previous accept, 0 = unchecked
   } vec_t;

   exp_t sb[$];
   int   last_acc = 0;
   int   last_pop = 0;
   int   wr_cnt = 0;
   int   rd_cnt = 0;
   bit   lat_done = 1'b0;

   // Present a request and wait (bounded) for it to be accepted.
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat,
                       input int nrd, input int gap);
      exp_t e;
      bit   acc;
      int   n;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
         @(negedge clk);
         acc = req_valid && req_ready;
         if (acc) begin
            e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err;
            e.lat = lat; e.nwr = we ? 1 : 0; e.nrd = nrd; e.acc = cyc + 1;
            sb.push_back(e);
            if (gap != 0) chk("accept_gap", 32'(cyc + 1 - last_acc), 32'(gap));
            last_acc = cyc + 1;
         end
         @(posedge clk); #1;
         n++;
      end
      chk("accept_timeout", {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Response monitor: strobe counting, latency, scoreboard pop on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         wr_cnt   = 0;
         rd_cnt   = 0;
         lat_done = 1'b0;
      end else begin
         if (mem_wr) begin
            wr_cnt++;
            if (sb.size() > 0) begin
               chk("wr_addr", mem_addr, sb[0].addr);
               chk("wr_data", mem_wdata, sb[0].wdata);
            end
         end
         if (mem_rd) begin
            rd_cnt++;
            if (sb.size() > 0) chk("rd_addr", mem_addr, sb[0].addr);
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
               if (!lat_done) begin
                  chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                  lat_done = 1'b1;
               end
               if (rsp_ready) begin
                  e = sb.pop_front();
                  chk("rsp_rdata", rsp_rdata, e.rdata);
                  chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                  chk("wr_strobes", 32'(wr_cnt), 32'(e.nwr));
                  chk("rd_strobes", 32'(rd_cnt), 32'(e.nrd));
                  wr_cnt   = 0;
                  rd_cnt   = 0;
                  lat_done = 1'b0;
                  last_pop = cyc + 1;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v[10];
      v[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        2, 0};
      v[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1, 4};
      v[2] = '{1'b1, 32'h0,  32'hA0,       32'h0,        2, 3};
      v[3] = '{1'b1, 32'h1,  32'hA1,       32'h0,        2, 4};
      v[4] = '{1'b1, 32'h2,  32'hA2,       32'h0,        2, 4};
      v[5] = '{1'b1, 32'h3,  32'hA3,       32'h0,        2, 4};
      v[6] = '{1'b0, 32'h0,  32'h0,        32'hA0,       1, 4};
      v[7] = '{1'b0, 32'h1,  32'h0,        32'hA1,       1, 3};
      v[8] = '{1'b0, 32'h2,  32'h0,        32'hA2,       1, 3};
      v[9] = '{1'b0, 32'h3,  32'h0,        32'hA3,       1, 3};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
      chk("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

      // Back-to-back table: store/load, then four stores and four loads.
      for (int i = 0; i < 10; i++)
         send(v[i].we, v[i].addr, v[i].wdata, v[i].rdata, 1'b0, v[i].lat,
              v[i].we ? 0 : 1, v[i].gap);
      req_valid = 1'b0;
      wait_idle();

      // Response stall with a new request held on the request channel.
      rsp_ready = 1'b0;
      send(1'b0, 32'h2, 32'h0, 32'hA2, 1'b0, 1, 1, 0);
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555; req_valid = 1'b1;
      @(posedge clk); #1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_rsp_rdata", rsp_rdata, 32'hA2);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
         chk("stall_mem_wr",    {31'd0, mem_wr},    32'd0);
         chk("stall_mem_rd",    {31'd0, mem_rd},    32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      send(1'b1, 32'h20, 32'h5555, 32'h0, 1'b0, 2, 0, 0);
      chk("accept_after_rsp", {31'd0, (last_acc > last_pop)}, 32'd1);
      req_valid = 1'b0;
      wait_idle();

      // Reset asserted while waiting for write completion.
      send(1'b1, 32'h30, 32'h77, 32'h0, 1'b0, 2, 0, 0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_mem_wr",    {31'd0, mem_wr},    32'd0);
      chk("midrst_mem_rd",    {31'd0, mem_rd},    32'd0);
      chk("midrst_mem_addr",  mem_addr,  32'd0);
      chk("midrst_mem_wdata", mem_wdata, 32'd0);
      chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
      chk("midrst_rsp_err",   {31'd0, rsp_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
      repeat (6) begin
         @(negedge clk);
         chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      @(posedge clk); #1;

`ifdef MEM_MASTER_TIMEOUT_EN
      // Memory never answers: load must time out after 16 read cycles.
      force_unavail = 1'b1;
      send(1'b0, 32'h1, 32'h0, 32'h0, 1'b1, 16, 16, 0);
      req_valid = 1'b0;
      wait_idle();
      force_unavail = 1'b0;
      // Normal load afterwards clears the error flag.
      send(1'b0, 32'h1, 32'h0, 32'hA1, 1'b0, 1, 1, 0);
      req_valid = 1'b0;
      wait_idle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
